// File: rtl/search_pkg.sv
// Shared defaults and FSM state type for the search result collector.
package search_pkg;
  localparam int DEF_IDX_W = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;
endpackage

// File: rtl/result_fifo.sv
// Show-ahead hit FIFO: head is valid in the same cycle the FIFO is non-empty.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Drive zero while empty so the head never exposes stale storage.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/search_result_collector.sv
// Collects hit indices of a search into a FIFO and summarises each search.
// Optional beat_count output is enabled by defining SRCH_COLLECT_STATS_EN.
module search_result_collector
  import search_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_hit,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] first_idx,
  output logic [IDX_W:0]   hit_count
`ifdef SRCH_COLLECT_STATS_EN
  ,
  output logic [IDX_W:0]   beat_count
`endif
);
  state_t state;
  state_t state_next;
  logic   accept;
  logic   push;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;

  // in_ready depends only on registered state, never on in_valid/out_ready.
  assign in_ready  = !fifo_full && (state != DONE);
  assign done      = (state == DONE);
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_hit;
  assign pop       = out_valid && out_ready;

  result_fifo #(
    .W     (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_idx),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = in_last ? DONE : COLLECT;
      COLLECT: if (accept && in_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first beat out of IDLE restarts the summary before folding in its own hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      found     <= 1'b0;
      first_idx <= '1;
      hit_count <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        found     <= in_hit;
        first_idx <= in_hit ? in_idx : '1;
        hit_count <= (IDX_W+1)'(in_hit);
      end else if (in_hit) begin
        if (!found) begin
          found     <= 1'b1;
          first_idx <= in_idx;
        end
        if (hit_count != '1) hit_count <= hit_count + (IDX_W+1)'(1);
      end
    end
  end

`ifdef SRCH_COLLECT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count <= '0;
    end else if (accept) begin
      if (state == IDLE)          beat_count <= (IDX_W+1)'(1);
      else if (beat_count != '1) beat_count <= beat_count + (IDX_W+1)'(1);
    end
  end
`endif
endmodule

// File: tb/tb_search_result_collector.sv
// Scoreboard bench for search_result_collector: stimulus pushes expectations, a monitor pops and compares.
module tb_search_result_collector;
  import search_pkg::*;

  localparam int IDX_W = 8;
  localparam int DEPTH = 4;
  localparam int SAT   = (1 << (IDX_W + 1)) - 1;
  localparam int NONE  = (1 << IDX_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_hit;
  logic [IDX_W-1:0] in_idx;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_ready;
  logic             done;
  logic             found;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W:0]   hit_count;
`ifdef SRCH_COLLECT_STATS_EN
  logic [IDX_W:0]   beat_count;
`endif

  typedef struct {
    bit found;
    int first;
    int hits;
    int beats;
  } exp_t;

  int   sbq[$];
  exp_t dq[$];
  bit   s_hit[$];
  int   s_idx[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;

  search_result_collector #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_hit    (in_hit),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .done      (done),
    .found     (found),
    .first_idx (first_idx),
    .hit_count (hit_count)
`ifdef SRCH_COLLECT_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Downstream consumer: 0 = stalled, 1 = always ready, 2 = random backpressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every popped index and every done summary against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sbq.size() == 0) checkOutput("spurious_out_valid", out_valid, 0);
        else if (out_ready)  checkOutput("out_idx", out_idx, sbq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) begin
          checkOutput("spurious_done", done, 0);
        end else begin
          exp_t e;
          e = dq.pop_front();
          checkOutput("found", found, e.found);
          checkOutput("first_idx", first_idx, e.first);
          checkOutput("hit_count", hit_count, e.hits);
`ifdef SRCH_COLLECT_STATS_EN
          checkOutput("beat_count", beat_count, e.beats);
`endif
        end
      end
    end
  end

  task automatic send_beat(input bit hit, input int idx, input bit last);
    int n;
    in_valid = 1'b1;
    in_hit   = hit;
    in_idx   = IDX_W'(idx);
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_hit   = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference model works on the whole search: expected hits in order plus the summary.
  task automatic applyStimulus(input bit with_last, input int gap_max);
    exp_t e;
    int   hits;
    e.found = 1'b0;
    e.first = NONE;
    hits    = 0;
    foreach (s_hit[i]) begin
      if (s_hit[i]) begin
        sbq.push_back(s_idx[i]);
        if (!e.found) begin
          e.found = 1'b1;
          e.first = s_idx[i];
        end
        hits++;
      end
    end
    e.hits  = (hits > SAT) ? SAT : hits;
    e.beats = (s_hit.size() > SAT) ? SAT : s_hit.size();
    if (with_last) dq.push_back(e);
    foreach (s_hit[i]) begin
      send_beat(s_hit[i], s_idx[i], with_last && (i == s_hit.size() - 1));
      if (gap_max > 0 && !(with_last && i == s_hit.size() - 1))
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
    end
    if (with_last) begin
      @(negedge clk);
      checkOutput("done_pulse", done, 1);
      checkOutput("in_ready_in_done", in_ready, 0);
    end
  endtask

  task automatic wait_drain();
    int n;
    rdy_mode = 1;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_left", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_hit   = 1'b0;
    in_idx   = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_found", found, 0);
    checkOutput("rst_first_idx", first_idx, NONE);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
`ifdef SRCH_COLLECT_STATS_EN
    checkOutput("rst_beat_count", beat_count, 0);
`endif

    // 16 beats with hits at 3, 7 and 12
    $display("[TB] directed: three hits in sixteen beats");
    rdy_mode = 1;
    s_hit.delete(); s_idx.delete();
    for (int i = 0; i < 16; i++) begin
      s_idx.push_back(i);
      s_hit.push_back(i == 3 || i == 7 || i == 12);
    end
    applyStimulus(1, 0);
    wait_drain();

    $display("[TB] directed: no hits");
    s_hit.delete(); s_idx.delete();
    for (int i = 0; i < 16; i++) begin
      s_idx.push_back(i);
      s_hit.push_back(1'b0);
    end
    applyStimulus(1, 0);
    wait_drain();

    // Stalled consumer fills the FIFO; the fifth hit must wait
    $display("[TB] directed: backpressure with six hits");
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    begin
      exp_t e;
      for (int i = 0; i < 6; i++) sbq.push_back(i);
      e.found = 1'b1; e.first = 0; e.hits = 6; e.beats = 6;
      dq.push_back(e);
      for (int i = 0; i < 4; i++) send_beat(1'b1, i, 1'b0);
      in_valid = 1'b1; in_hit = 1'b1; in_idx = IDX_W'(4); in_last = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_full", in_ready, 0);
      checkOutput("out_head_full", out_idx, 0);
      rdy_mode = 1;
      send_beat(1'b1, 4, 1'b0);
      send_beat(1'b1, 5, 1'b1);
      @(negedge clk);
      checkOutput("done_pulse_bp", done, 1);
    end
    wait_drain();

    $display("[TB] directed: single-beat search");
    s_hit.delete(); s_idx.delete();
    s_hit.push_back(1'b1); s_idx.push_back(9);
    applyStimulus(1, 0);
    wait_drain();

    $display("[TB] random searches with random backpressure");
    rdy_mode = 2;
    for (int s = 0; s < 20; s++) begin
      int len;
      len = $urandom_range(1, 16);
      s_hit.delete(); s_idx.delete();
      for (int i = 0; i < len; i++) begin
        s_idx.push_back($urandom_range(0, NONE));
        s_hit.push_back($urandom_range(0, 99) < 40);
      end
      applyStimulus(1, 1);
    end
    wait_drain();

    $display("[TB] saturation: 600 hits in one search");
    s_hit.delete(); s_idx.delete();
    for (int i = 0; i < 600; i++) begin
      s_idx.push_back($urandom_range(0, NONE));
      s_hit.push_back(1'b1);
    end
    applyStimulus(1, 0);
    wait_drain();

    // Reset in the middle of a search with three hits buffered
    $display("[TB] reset mid-search");
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    s_hit.delete(); s_idx.delete();
    s_hit.push_back(1'b1); s_idx.push_back(1);
    s_hit.push_back(1'b1); s_idx.push_back(2);
    s_hit.push_back(1'b1); s_idx.push_back(3);
    s_hit.push_back(1'b0); s_idx.push_back(4);
    applyStimulus(0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    dq.delete();
    @(negedge clk);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_hit_count", hit_count, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_found", found, 0);
    checkOutput("mid_rst_first_idx", first_idx, NONE);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] search after reset");
    rdy_mode = 2;
    s_hit.delete(); s_idx.delete();
    for (int i = 0; i < 10; i++) begin
      s_idx.push_back(20 + i);
      s_hit.push_back(i == 2 || i == 5);
    end
    applyStimulus(1, 1);
    wait_drain();

    checkOutput("pending_done", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
